// File: rtl/pc_fetch.sv
// pc_fetch: program counter and instruction-fetch stage of the sisc processor.
//   Holds the PC, reads 32-bit words from instruction memory over a req/ack
//   handshake and presents each one to decode in a held instruction register.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   br_addr, br_taken   branch target / take-branch, sampled on the accept edge only
//   stall, ir_accept    decode hold / decode consumed ir (accept = ir_accept & ~stall)
//   imem_rdata/ack      memory read data and completion
//   imem_req/addr       read request and word address (addr == pc)
//   ir, ir_valid        held instruction word and its valid flag
//   pc, pc_inc          current PC and pc+1 (mod 2^16) for the branch adder
//   fetch_err           sticky memory-timeout flag, cleared only by rst
module pc_fetch #(
  parameter logic [15:0] RESET_ADDR = 16'h0000,
  parameter int          TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] br_addr,
  input  logic        br_taken,
  input  logic        stall,
  input  logic        ir_accept,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic [15:0] pc,
  output logic [15:0] pc_inc,
  output logic        fetch_err
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_ERR} state_t;

  // Last count value before the timeout fires: the TIMEOUT-th unacked
  // request cycle ends with the error.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  logic       ack_hit, timeout_hit, accept;

  assign pc_inc    = pc + 16'd1;
  assign imem_addr = pc;

  // imem_req is only ever high in FETCH, so gating with it also drops acks
  // seen in HOLD/ERR and the one FETCH cycle right after reset.
  assign ack_hit     = imem_req & imem_ack;
  assign timeout_hit = imem_req & ~imem_ack & (wait_cnt == TO_LAST);
  assign accept      = (state == S_HOLD) & ir_accept & ~stall;

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: if (ack_hit)          state_nxt = S_HOLD;
               else if (timeout_hit) state_nxt = S_ERR;
      S_HOLD:  if (accept)           state_nxt = S_FETCH;
      S_ERR:                         state_nxt = S_ERR;
      default:                       state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= RESET_ADDR;
      ir        <= 32'h0;
      ir_valid  <= 1'b0;
      imem_req  <= 1'b0;
      fetch_err <= 1'b0;
      wait_cnt  <= 8'd0;
    end else begin
      state    <= state_nxt;
      // Registered request: rises one cycle after reset release and
      // immediately after each accept, drops on ack or timeout.
      imem_req <= (state_nxt == S_FETCH);
      if (ack_hit) begin
        ir       <= imem_rdata;
        ir_valid <= 1'b1;
        wait_cnt <= 8'd0;
      end else if (timeout_hit) begin
        fetch_err <= 1'b1;
        wait_cnt  <= 8'd0;
      end else if (imem_req) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (accept) begin
        pc       <= br_taken ? br_addr : pc_inc;
        ir_valid <= 1'b0;
      end
    end
  end

endmodule
